// File: rtl/game_pkg.sv
// Shared definitions for the enemy table: record layout, table geometry,
// spawner state encoding and the column mapping helper.
package game_pkg;

  localparam int ENEMY_W     = 24;
  localparam int TABLE_DEPTH = 64;
  localparam int TABLE_AW    = 6;
  localparam int LFSR_W      = 12;

  localparam int ROW_MSB   = 23;
  localparam int ROW_LSB   = 13;
  localparam int COL_MSB   = 12;
  localparam int COL_LSB   = 1;
  localparam int VALID_BIT = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_GNT,
    ST_SCAN,
    ST_WRITE,
    ST_DONE
  } spawnState_t;

  // Folds an 11-bit random value into the visible column range and aligns it
  // to a 4-pixel boundary. A single subtraction suffices because the limit is
  // at least 1024, so the folded value is always below the limit.
  function automatic logic [11:0] spawnColumn(input logic [10:0] v,
                                              input logic [11:0] limit);
    logic [11:0] c;
    c = {1'b0, v};
    if (c >= limit) begin
      c = c - limit;
    end
    c[1:0] = 2'b00;
    return c;
  endfunction

endpackage

// File: rtl/spawn_lfsr.sv
// 12-bit Fibonacci LFSR (taps 12,11,10,4) used as the spawn column source.
// The feedback is invertible, so a nonzero seed never reaches the all-zero state.
module spawn_lfsr
  import game_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 12'hACE
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable_i,
  output logic [LFSR_W-1:0] lfsr_o
);

  logic [LFSR_W-1:0] lfsr_q;

  // Shift register with XOR feedback; reloads the seed on reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr_q <= SEED;
    end else if (enable_i) begin
      lfsr_q <= {lfsr_q[10:0], lfsr_q[11] ^ lfsr_q[10] ^ lfsr_q[9] ^ lfsr_q[3]};
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/enemy_spawner.sv
// Enemy spawner: periodically requests the enemy table during the calc phase,
// scans for the first free slot and writes a fresh record into it.
// Optional build macro ENEMY_SPAWN_DROP_CNT_EN adds a saturating drop_count
// output counting merged spawn requests and full-table attempts.
module enemy_spawner
  import game_pkg::*;
#(
  parameter int unsigned       SPAWN_PERIOD = 33554432,
  parameter int unsigned       H_ACTIVE     = 1280,
  parameter int unsigned       SIZE         = 64,
  parameter logic [LFSR_W-1:0] LFSR_SEED    = 12'hACE
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                calc,
  output logic                table_req,
  input  logic                table_gnt,
  output logic [TABLE_AW-1:0] rd_addr,
  input  logic [ENEMY_W-1:0]  rd_data,
  output logic [TABLE_AW-1:0] wr_addr,
  output logic [ENEMY_W-1:0]  wr_data,
  output logic                wr_en,
  output logic                spawned,
  output logic                table_full,
  output logic [15:0]         spawn_count
`ifdef ENEMY_SPAWN_DROP_CNT_EN
  ,
  output logic [7:0]          drop_count
`endif
);

  localparam int unsigned         CNT_W     = $clog2(SPAWN_PERIOD);
  localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(SPAWN_PERIOD - 1);
  localparam logic [11:0]         COL_LIMIT = 12'(H_ACTIVE - SIZE);
  localparam logic [TABLE_AW-1:0] LAST_IDX  = TABLE_AW'(TABLE_DEPTH - 1);

  spawnState_t         state_q, state_d;
  logic                req_q, req_d;
  logic [TABLE_AW-1:0] rdAddr_q, rdAddr_d;
  logic [TABLE_AW-1:0] idx_q, idx_d;
  logic                dataValid_q, dataValid_d;
  logic [TABLE_AW-1:0] wrAddr_q, wrAddr_d;
  logic [ENEMY_W-1:0]  wrData_q, wrData_d;
  logic                pending_q;
  logic [CNT_W-1:0]    periodCnt_q;
  logic                full_q;
  logic [15:0]         count_q;
  logic [LFSR_W-1:0]   lfsrValue;
  logic                wrap;
  logic                owned;
  logic                writeNow;
  logic                fullEvent;
  logic                rdDataUnused;

  spawn_lfsr #(.SEED(LFSR_SEED)) uLfsr (
    .clock    (clock),
    .reset    (reset),
    .enable_i (1'b1),
    .lfsr_o   (lfsrValue)
  );

  assign wrap     = (periodCnt_q == CNT_LAST);
  assign owned    = req_q && table_gnt && calc;
  assign writeNow = (state_q == ST_WRITE) && owned && !reset;

  assign rdDataUnused = ^{rd_data[ENEMY_W-1:1], lfsrValue[LFSR_W-1]};

  // Sequential state: FSM registers, period counter, pending flag and status.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      req_q       <= 1'b0;
      rdAddr_q    <= '0;
      idx_q       <= '0;
      dataValid_q <= 1'b0;
      wrAddr_q    <= '0;
      wrData_q    <= '0;
      pending_q   <= 1'b0;
      periodCnt_q <= '0;
      full_q      <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      rdAddr_q    <= rdAddr_d;
      idx_q       <= idx_d;
      dataValid_q <= dataValid_d;
      wrAddr_q    <= wrAddr_d;
      wrData_q    <= wrData_d;
      periodCnt_q <= wrap ? '0 : periodCnt_q + CNT_W'(1);
      if (wrap) begin
        pending_q <= 1'b1;
      end else if (writeNow || fullEvent) begin
        pending_q <= 1'b0;
      end
      if (writeNow) begin
        full_q  <= 1'b0;
        count_q <= count_q + 16'd1;
      end else if (fullEvent) begin
        full_q <= 1'b1;
      end
    end
  end

  // Next-state logic: request, scan with one-cycle read latency, write, release.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    rdAddr_d    = rdAddr_q;
    idx_d       = idx_q;
    dataValid_d = dataValid_q;
    wrAddr_d    = wrAddr_q;
    wrData_d    = wrData_q;
    fullEvent   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pending_q && calc) begin
          req_d   = 1'b1;
          state_d = ST_WAIT_GNT;
        end
      end
      ST_WAIT_GNT: begin
        if (!calc) begin
          req_d   = 1'b0;
          state_d = ST_IDLE;
        end else if (table_gnt) begin
          rdAddr_d    = '0;
          dataValid_d = 1'b0;
          state_d     = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (!owned) begin
          req_d   = 1'b0;
          state_d = ST_IDLE;
        end else begin
          rdAddr_d    = (rdAddr_q == LAST_IDX) ? LAST_IDX : rdAddr_q + TABLE_AW'(1);
          idx_d       = rdAddr_q;
          dataValid_d = 1'b1;
          if (dataValid_q) begin
            if (!rd_data[VALID_BIT]) begin
              wrAddr_d                   = idx_q;
              wrData_d                   = '0;
              wrData_d[COL_MSB:COL_LSB]  = spawnColumn(lfsrValue[10:0], COL_LIMIT);
              wrData_d[VALID_BIT]        = 1'b1;
              state_d                    = ST_WRITE;
            end else if (idx_q == LAST_IDX) begin
              fullEvent = 1'b1;
              req_d     = 1'b0;
              state_d   = ST_DONE;
            end
          end
        end
      end
      ST_WRITE: begin
        req_d   = 1'b0;
        state_d = owned ? ST_DONE : ST_IDLE;
      end
      ST_DONE: begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef ENEMY_SPAWN_DROP_CNT_EN
  logic [7:0] dropCnt_q;

  // Saturating count of merged period wraps and full-table attempts.
  always_ff @(posedge clock) begin
    if (reset) begin
      dropCnt_q <= '0;
    end else if (((wrap && pending_q) || fullEvent) && (dropCnt_q != 8'hFF)) begin
      dropCnt_q <= dropCnt_q + 8'd1;
    end
  end

  assign drop_count = dropCnt_q;
`endif

  assign table_req   = req_q;
  assign rd_addr     = rdAddr_q;
  assign wr_addr     = wrAddr_q;
  assign wr_data     = wrData_q;
  assign wr_en       = writeNow;
  assign spawned     = writeNow;
  assign table_full  = full_q;
  assign spawn_count = count_q;

endmodule

// File: tb/tb_enemy_spawner.sv
// Testbench for enemy_spawner: emulates the enemy table with one-cycle read
// latency, keeps a reference LFSR and column model, and checks spawn slot,
// record contents, latency, full-table handling, aborts and reset.
module tb_enemy_spawner;

  localparam int          P        = 16;
  localparam int          H_ACTIVE = 1280;
  localparam int          SIZE     = 64;
  localparam logic [11:0] SEED     = 12'hACE;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        calc = 1'b0;
  logic        gntEnable = 1'b1;
  logic        table_req;
  logic        table_gnt;
  logic [5:0]  rd_addr;
  logic [23:0] rd_data;
  logic [5:0]  wr_addr;
  logic [23:0] wr_data;
  logic        wr_en;
  logic        spawned;
  logic        table_full;
  logic [15:0] spawn_count;
`ifdef ENEMY_SPAWN_DROP_CNT_EN
  logic [7:0]  drop_count;
`endif

  int checks = 0;
  int failures = 0;
  int cycleNo = 0;
  int wrCount = 0;
  logic [23:0] mem [64];
  logic [11:0] curL = SEED;
  logic [11:0] lastL = SEED;

  assign table_gnt = table_req && gntEnable;

  enemy_spawner #(
    .SPAWN_PERIOD (P),
    .H_ACTIVE     (H_ACTIVE),
    .SIZE         (SIZE),
    .LFSR_SEED    (SEED)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .calc        (calc),
    .table_req   (table_req),
    .table_gnt   (table_gnt),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_en       (wr_en),
    .spawned     (spawned),
    .table_full  (table_full),
    .spawn_count (spawn_count)
`ifdef ENEMY_SPAWN_DROP_CNT_EN
    ,
    .drop_count  (drop_count)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [11:0] lfsrStep(input logic [11:0] v);
    return {v[10:0], v[11] ^ v[10] ^ v[9] ^ v[3]};
  endfunction

  // Column rule from plain arithmetic: fold into range, round down to 4.
  function automatic logic [11:0] expectCol(input logic [11:0] v);
    int c;
    c = int'(v) % 2048;
    if (c >= H_ACTIVE - SIZE) c = c - (H_ACTIVE - SIZE);
    c = (c / 4) * 4;
    return 12'(c);
  endfunction

  // Table emulation, cycle counter and reference LFSR.
  always @(posedge clock) begin
    cycleNo++;
    lastL = curL;
    curL  = reset ? SEED : lfsrStep(curL);
    rd_data <= mem[rd_addr];
    if (wr_en) begin
      mem[wr_addr] = wr_data;
      wrCount++;
    end
    if (reset) wrCount = 0;
  end

  // sel 0: req high, 1: req low, 2: wr_en high; returns at that negedge.
  task automatic waitFor(input int sel, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clock);
      if ((sel == 0 && table_req === 1'b1) || (sel == 1 && table_req === 1'b0) ||
          (sel == 2 && wr_en === 1'b1)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic fillTable(input int k, input bit allValid);
    for (int i = 0; i < 64; i++) begin
      mem[i] = 24'($urandom);
      if (allValid || i < k) mem[i][0] = 1'b1;
      else if (i == k) mem[i][0] = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; calc = 1'b0; gntEnable = 1'b1;
    for (int i = 0; i < 64; i++) mem[i] = 24'd0;
    repeat (3) @(negedge clock);
    checks++;
    if ({table_req, wr_en, spawned, table_full} !== 4'b0) begin
      failures++; $display("[TB] FAIL reset_flags got=%b want=0000", {table_req, wr_en, spawned, table_full});
    end
    checks++;
    if ({rd_addr, wr_addr} !== 12'd0) begin
      failures++; $display("[TB] FAIL reset_addr got=%h want=000", {rd_addr, wr_addr});
    end
    checks++;
    if (wr_data !== 24'd0 || spawn_count !== 16'd0) begin
      failures++; $display("[TB] FAIL reset_data got=%h/%0d want=0/0", wr_data, spawn_count);
    end
  endtask

  task automatic test_first_spawn();
    int base, g, w;
    bit ok;
    reset = 1'b0; calc = 1'b1; base = cycleNo;
    waitFor(0, 40, ok); g = cycleNo;
    checks++;
    if (!ok || g != base + P + 1) begin
      failures++; $display("[TB] FAIL first_req_cycle got=%0d want=%0d", g - base, P + 1);
    end
    waitFor(2, 80, ok); w = cycleNo;
    checks++;
    if (!ok || w - g != 3 || wr_addr !== 6'd0) begin
      failures++; $display("[TB] FAIL first_write got=lat%0d/addr%0d want=lat3/addr0", w - g, wr_addr);
    end
    checks++;
    if (wr_data !== {11'd0, expectCol(lastL), 1'b1} || spawned !== 1'b1) begin
      failures++; $display("[TB] FAIL first_record got=%h/%b want=%h/1", wr_data, spawned, {11'd0, expectCol(lastL), 1'b1});
    end
    @(negedge clock);
    checks++;
    if (spawned !== 1'b0 || spawn_count !== 16'd1) begin
      failures++; $display("[TB] FAIL first_count got=%b/%0d want=0/1", spawned, spawn_count);
    end
  endtask

  task automatic test_slot5();
    int g, w;
    bit ok;
    waitFor(1, 10, ok);
    fillTable(5, 1'b0);
    waitFor(0, 40, ok); g = cycleNo;
    waitFor(2, 80, ok); w = cycleNo;
    checks++;
    if (!ok || w - g != 8 || wr_addr !== 6'd5) begin
      failures++; $display("[TB] FAIL slot5 got=lat%0d/addr%0d want=lat8/addr5", w - g, wr_addr);
    end
  endtask

  task automatic test_random_spawns();
    int g, w, k, d;
    bit ok;
    for (int n = 0; n < 8; n++) begin
      waitFor(1, 10, ok);
      calc = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clock);
      k = $urandom_range(0, 63);
      fillTable(k, 1'b0);
      gntEnable = 1'b0; calc = 1'b1;
      waitFor(0, 40, ok);
      d = $urandom_range(0, 4);
      repeat (d) @(negedge clock);
      gntEnable = 1'b1; g = cycleNo;
      waitFor(2, 80, ok); w = cycleNo;
      checks++;
      if (!ok || w - g != 3 + k || wr_addr !== 6'(k)) begin
        failures++; $display("[TB] FAIL rand_slot got=lat%0d/addr%0d want=lat%0d/addr%0d", w - g, wr_addr, 3 + k, k);
      end
      checks++;
      if (wr_data !== {11'd0, expectCol(lastL), 1'b1}) begin
        failures++; $display("[TB] FAIL rand_record got=%h want=%h", wr_data, {11'd0, expectCol(lastL), 1'b1});
      end
      @(negedge clock);
      checks++;
      if (spawn_count !== 16'(wrCount)) begin
        failures++; $display("[TB] FAIL rand_count got=%0d want=%0d", spawn_count, wrCount);
      end
    end
  endtask

  task automatic test_table_full();
    int g, f, w, wc;
    bit ok;
    waitFor(1, 10, ok);
    fillTable(0, 1'b1);
    waitFor(0, 40, ok); g = cycleNo; wc = wrCount;
    waitFor(1, 100, ok); f = cycleNo;
    checks++;
    if (!ok || f - g != 66 || wrCount != wc) begin
      failures++; $display("[TB] FAIL full_scan got=own%0d/writes%0d want=own66/writes0", f - g, wrCount - wc);
    end
    checks++;
    if (table_full !== 1'b1) begin
      failures++; $display("[TB] FAIL full_flag got=%b want=1", table_full);
    end
    mem[63][0] = 1'b0;
    waitFor(0, 40, ok); g = cycleNo;
    waitFor(2, 80, ok); w = cycleNo;
    checks++;
    if (!ok || w - g != 66 || wr_addr !== 6'd63) begin
      failures++; $display("[TB] FAIL full_retry got=lat%0d/addr%0d want=lat66/addr63", w - g, wr_addr);
    end
    @(negedge clock);
    checks++;
    if (table_full !== 1'b0) begin
      failures++; $display("[TB] FAIL full_clear got=%b want=0", table_full);
    end
  endtask

  task automatic test_abort();
    int g, w, wc, m;
    bit ok;
    waitFor(1, 10, ok);
    fillTable(16, 1'b0);
    waitFor(0, 40, ok); g = cycleNo;
    while (cycleNo < g + 12) @(negedge clock);
    calc = 1'b0; wc = wrCount;
    @(negedge clock);
    checks++;
    if (table_req !== 1'b0) begin
      failures++; $display("[TB] FAIL abort_req got=%b want=0", table_req);
    end
    repeat (4) @(negedge clock);
    calc = 1'b1; m = cycleNo;
    @(negedge clock);
    checks++;
    if (table_req !== 1'b1 || wrCount != wc) begin
      failures++; $display("[TB] FAIL abort_retry got=req%b/writes%0d want=req1/writes0", table_req, wrCount - wc);
    end
    waitFor(2, 80, ok); w = cycleNo;
    checks++;
    if (!ok || wr_addr !== 6'd16 || w - (m + 1) != 19) begin
      failures++; $display("[TB] FAIL abort_write got=addr%0d/lat%0d want=addr16/lat19", wr_addr, w - (m + 1));
    end
    waitFor(1, 10, ok);
    mem[16][0] = 1'b0;
    waitFor(0, 40, ok); g = cycleNo;
    while (cycleNo < g + 5) @(negedge clock);
    gntEnable = 1'b0; wc = wrCount;
    @(negedge clock);
    checks++;
    if (table_req !== 1'b0) begin
      failures++; $display("[TB] FAIL gnt_abort_req got=%b want=0", table_req);
    end
    gntEnable = 1'b1;
    waitFor(2, 120, ok);
    checks++;
    if (!ok || wr_addr !== 6'd16 || wrCount != wc) begin
      failures++; $display("[TB] FAIL gnt_abort_write got=addr%0d/writes%0d want=addr16/writes0", wr_addr, wrCount - wc);
    end
  endtask

  task automatic test_col_7ff();
    logic [11:0] l;
    int k;
    bit ok, found;
    waitFor(1, 10, ok);
    calc = 1'b0;
    repeat (P + 2) @(negedge clock);
    found = 1'b0; k = 0;
    for (int t = 0; t < 5000 && !found; t++) begin
      l = curL;
      for (int j = 1; j <= 66; j++) begin
        l = lfsrStep(l);
        if (j >= 3 && l[10:0] == 11'h7FF) begin
          k = j - 3; found = 1'b1; break;
        end
      end
      if (!found) @(negedge clock);
    end
    if (found) begin
      fillTable(k, 1'b0);
      calc = 1'b1;
      waitFor(2, 80, ok);
    end else ok = 1'b0;
    checks++;
    if (!ok || wr_data[12:1] !== 12'd828 || wr_addr !== 6'(k)) begin
      failures++; $display("[TB] FAIL col_7ff got=col%0d/addr%0d want=col828/addr%0d", wr_data[12:1], wr_addr, k);
    end
  endtask

  task automatic test_reset_in_write();
    bit ok;
    waitFor(1, 10, ok);
    fillTable($urandom_range(0, 8), 1'b0);
    calc = 1'b1;
    waitFor(2, 80, ok);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (!ok || {wr_en, spawned, table_req, table_full} !== 4'b0 || spawn_count !== 16'd0 ||
        wr_data !== 24'd0 || {rd_addr, wr_addr} !== 12'd0) begin
      failures++; $display("[TB] FAIL reset_write got=%b/%0d/%h want=0000/0/0", {wr_en, spawned, table_req, table_full}, spawn_count, wr_data);
    end
`ifdef ENEMY_SPAWN_DROP_CNT_EN
    checks++;
    if (drop_count !== 8'd0) begin
      failures++; $display("[TB] FAIL reset_drop got=%0d want=0", drop_count);
    end
`endif
    reset = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_first_spawn();
    test_slot5();
    test_random_spawns();
    test_table_full();
    test_abort();
    test_col_7ff();
    test_reset_in_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
